match_controller: RTL and testbench

Round/match sequencer that sits between the board's enter button and the Bulls & Cows game core. It debounces the button, forwards presses to the game only while a round is live, and issues a one-cycle game reset at the start of every round. It also tracks per-player round wins, alternates which player sets the secret code, and declares a first-to-`WIN_TARGET` match winner. The score outputs feed the LED scoreboard; `game_reset` and `game_enter` replace the direct reset/enter wiring of the game core.

---
 rtl/match_controller.sv | 217 +++++++++++++++++++++
 tb/tb_match_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// match_controller
//
// Round/match sequencer between the board's enter button and the Bulls & Cows
// game core. Debounces the button, forwards presses to the game only while a
// round is live, pulses the game reset at the start of every round, keeps
// per-player round wins, alternates the code setter and declares the player
// who first reaches WIN_TARGET round wins.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a new button level is accepted (>=1)
//   HOLD_CYCLES      length of the round-result pause in cycles (>=1)
//   WIN_TARGET       round wins needed to take the match (1..15)
//
// Ports:
//   clock         in   single rising-edge clock
//   reset         in   synchronous active-high reset
//   enter_button  in   raw asynchronous push button
//   p1_win        in   one-cycle pulse: player 1 guessed the code
//   p2_win        in   one-cycle pulse: player 2 guessed the code
//   game_enter    out  one-cycle enter pulse to the game core (PLAYING only)
//   game_reset    out  game core reset (during reset and in ROUND_START)
//   setter        out  0 = player 1 sets the secret, 1 = player 2
//   p1_score      out  player 1 round wins this match
//   p2_score      out  player 2 round wins this match
//   round_num     out  rounds completed this match (wraps modulo 32)
//   match_over    out  high while the match result is shown
//   match_winner  out  01 player 1, 10 player 2, 00 none

module match_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 200_000_000,
    parameter int WIN_TARGET      = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter_button,
    input  logic       p1_win,
    input  logic       p2_win,
    output logic       game_enter,
    output logic       game_reset,
    output logic       setter,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [4:0] round_num,
    output logic       match_over,
    output logic [1:0] match_winner
);

    localparam int              DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LIMIT   = DB_W'(DEBOUNCE_CYCLES);
    localparam int              HOLD_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]      TARGET     = 4'(WIN_TARGET);

    typedef enum logic [2:0] {
        IDLE,
        ROUND_START,
        PLAYING,
        ROUND_END,
        MATCH_OVER
    } state_t;

    state_t state;
    state_t next_state;

    logic              sync_ff1;
    logic              sync_ff2;
    logic              db_level;
    logic [DB_W-1:0]   db_count;
    logic              enter_pulse;
    logic [HOLD_W-1:0] hold_count;
    logic              hold_done;
    logic              target_hit;

    // Button path: two-flop synchronizer, then a counter that runs only while
    // the synchronized level disagrees with the accepted level. Any glitch back
    // to the accepted level restarts it. The press pulse is produced on the
    // same edge the accepted level rises, so one held press gives one pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_ff1    <= 1'b0;
            sync_ff2    <= 1'b0;
            db_level    <= 1'b0;
            db_count    <= '0;
            enter_pulse <= 1'b0;
        end else begin
            sync_ff1    <= enter_button;
            sync_ff2    <= sync_ff1;
            enter_pulse <= 1'b0;
            if (sync_ff2 == db_level) begin
                db_count <= '0;
            end else if (db_count == DB_LIMIT) begin
                db_level    <= sync_ff2;
                db_count    <= '0;
                enter_pulse <= sync_ff2;
            end else begin
                db_count <= db_count + DB_W'(1);
            end
        end
    end

    // The result pause is counted from zero on entry to ROUND_END, so the
    // state is held for exactly HOLD_CYCLES cycles.
    assign hold_done  = (state == ROUND_END) && (hold_count == HOLD_LAST);
    assign target_hit = (p1_score == TARGET) || (p2_score == TARGET);

    // State register plus the result-pause counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            hold_count <= '0;
        end else begin
            state <= next_state;
            if ((state == ROUND_END) && !hold_done) begin
                hold_count <= hold_count + HOLD_W'(1);
            end else begin
                hold_count <= '0;
            end
        end
    end

    // Next-state logic and the two combinational outputs. game_reset follows
    // the reset input directly so the core is held in reset with us.
    always_comb begin
        next_state = state;
        game_enter = 1'b0;
        game_reset = reset;
        case (state)
            IDLE: begin
                if (enter_pulse) begin
                    next_state = ROUND_START;
                end
            end
            ROUND_START: begin
                game_reset = 1'b1;
                next_state = PLAYING;
            end
            PLAYING: begin
                game_enter = enter_pulse && !reset;
                if (p1_win || p2_win) begin
                    next_state = ROUND_END;
                end
            end
            ROUND_END: begin
                if (hold_done) begin
                    next_state = target_hit ? MATCH_OVER : ROUND_START;
                end
            end
            MATCH_OVER: begin
                if (enter_pulse) begin
                    next_state = ROUND_START;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Score keeping. A simultaneous win by both players is a draw: the round
    // still counts but nobody scores. The score guards only matter if the
    // core misbehaves; a match always ends as soon as one score hits target.
    always_ff @(posedge clock) begin
        if (reset) begin
            p1_score  <= '0;
            p2_score  <= '0;
            round_num <= '0;
            setter    <= 1'b0;
        end else begin
            case (state)
                PLAYING: begin
                    if (p1_win && !p2_win && (p1_score != TARGET)) begin
                        p1_score <= p1_score + 4'd1;
                    end
                    if (p2_win && !p1_win && (p2_score != TARGET)) begin
                        p2_score <= p2_score + 4'd1;
                    end
                    if (p1_win || p2_win) begin
                        round_num <= round_num + 5'd1;
                    end
                end
                ROUND_END: begin
                    if (hold_done && !target_hit) begin
                        setter <= ~setter;
                    end
                end
                MATCH_OVER: begin
                    if (enter_pulse) begin
                        p1_score  <= '0;
                        p2_score  <= '0;
                        round_num <= '0;
                        setter    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Match result flags are registered from next_state so they track the
    // MATCH_OVER state exactly; scores are already final when it is entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            match_over   <= 1'b0;
            match_winner <= 2'b00;
        end else begin
            match_over <= (next_state == MATCH_OVER);
            if (next_state == MATCH_OVER) begin
                match_winner <= (p1_score == TARGET) ? 2'b01 : 2'b10;
            end else begin
                match_winner <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller
//
// Bench for match_controller with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8,
// WIN_TARGET=2. Forwarded enter presses are tracked by a queue of expected
// game_enter cycles; round outcomes come from a table of win vectors.

module tb_match_controller;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int TGT  = 2;
    localparam int ENTER_LATENCY = DB + 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       enter_button;
    logic       p1_win;
    logic       p2_win;
    logic       game_enter;
    logic       game_reset;
    logic       setter;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [4:0] round_num;
    logic       match_over;
    logic [1:0] match_winner;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int exp_q[$];

    typedef struct {
        logic p1w;
        logic p2w;
        int   e_p1;
        int   e_p2;
        int   e_round;
        int   e_setter;
        int   e_over;
        int   e_winner;
    } vec_t;

    vec_t vecs[4];

    match_controller #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_CYCLES(HOLD),
        .WIN_TARGET(TGT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enter_button(enter_button),
        .p1_win(p1_win),
        .p2_win(p2_win),
        .game_enter(game_enter),
        .game_reset(game_reset),
        .setter(setter),
        .p1_score(p1_score),
        .p2_score(p2_score),
        .round_num(round_num),
        .match_over(match_over),
        .match_winner(match_winner)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string name, input int e_p1, input int e_p2, input int e_round,
                            input int e_setter, input int e_over, input int e_winner);
        checkOutput({name, " p1_score"},     32'(p1_score),     e_p1);
        checkOutput({name, " p2_score"},     32'(p2_score),     e_p2);
        checkOutput({name, " round_num"},    32'(round_num),    e_round);
        checkOutput({name, " setter"},       32'(setter),       e_setter);
        checkOutput({name, " match_over"},   32'(match_over),   e_over);
        checkOutput({name, " match_winner"}, 32'(match_winner), e_winner);
    endtask

    // Clean press and release; when forwarded, the game_enter cycle is queued.
    task automatic applyStimulus(input bit forwarded);
        enter_button = 1'b1;
        if (forwarded) exp_q.push_back(cyc + ENTER_LATENCY);
        repeat (12) tick();
        enter_button = 1'b0;
        repeat (12) tick();
    endtask

    // Scoreboard: every game_enter pulse must match the oldest queued cycle.
    always @(negedge clock) begin : enter_monitor
        int e;
        if (game_enter !== 1'b0) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected game_enter: got %b at cycle %0d, expected 0", game_enter, cyc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("game_enter cycle", cyc, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d, expected earlier finish", cyc);
        $fatal(1, "[TB] timeout");
    end

    initial begin : main
        int c0;
        int gr_first;
        int gr_count;
        int n;
        int highs;

        vecs[0] = '{1'b1, 1'b0, 1, 0, 1, 1, 0, 0};
        vecs[1] = '{1'b1, 1'b1, 1, 0, 2, 0, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 1, 1, 3, 1, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 1, 2, 4, 1, 1, 2};

        reset        = 1'b1;
        enter_button = 1'b0;
        p1_win       = 1'b0;
        p2_win       = 1'b0;
        repeat (3) tick();
        checkOutput("game_reset during reset", 32'(game_reset), 1);
        reset = 1'b0;
        tick();
        checkAll("after reset", 0, 0, 0, 0, 0, 0);
        checkOutput("game_reset in IDLE", 32'(game_reset), 0);

        // A win pulse in IDLE is ignored.
        p2_win = 1'b1;
        tick();
        p2_win = 1'b0;
        tick();
        checkAll("p2_win in IDLE", 0, 0, 0, 0, 0, 0);

        // Bouncy press 1/0/1 then held; the stable rise is the third cycle.
        c0       = cyc;
        gr_first = -1;
        gr_count = 0;
        for (int i = 0; i < 20; i++) begin
            enter_button = (i == 1) ? 1'b0 : 1'b1;
            tick();
            if (game_reset) begin
                if (gr_first < 0) gr_first = cyc;
                gr_count++;
            end
        end
        checkOutput("first game_reset cycle", gr_first, c0 + 2 + ENTER_LATENCY + 1);
        checkOutput("first game_reset width", gr_count, 1);
        enter_button = 1'b0;
        repeat (12) tick();

        // Two presses while PLAYING are forwarded.
        applyStimulus(1'b1);
        applyStimulus(1'b1);

        for (int v = 0; v < 4; v++) begin
            p1_win = vecs[v].p1w;
            p2_win = vecs[v].p2w;
            tick();
            p1_win = 1'b0;
            p2_win = 1'b0;
            checkOutput($sformatf("vec%0d p1_score", v), 32'(p1_score), vecs[v].e_p1);
            checkOutput($sformatf("vec%0d p2_score", v), 32'(p2_score), vecs[v].e_p2);
            checkOutput($sformatf("vec%0d round_num", v), 32'(round_num), vecs[v].e_round);
            if (v == 0) enter_button = 1'b1;
            n = 0;
            while (!(game_reset || match_over) && n < 50) begin
                p2_win = (v == 0 && n == 2) ? 1'b1 : 1'b0;
                tick();
                n++;
            end
            p2_win = 1'b0;
            checkOutput($sformatf("vec%0d hold length", v), n, HOLD);
            checkAll($sformatf("vec%0d after hold", v), vecs[v].e_p1, vecs[v].e_p2, vecs[v].e_round,
                     vecs[v].e_setter, vecs[v].e_over, vecs[v].e_winner);
            if (vecs[v].e_over == 0) begin
                tick();
                checkOutput($sformatf("vec%0d game_reset one cycle", v), 32'(game_reset), 0);
            end
            if (v == 0) begin
                enter_button = 1'b0;
                repeat (12) tick();
            end
        end

        // Win pulses in MATCH_OVER are ignored.
        p2_win = 1'b1;
        tick();
        p2_win = 1'b0;
        tick();
        checkAll("p2_win in MATCH_OVER", 1, 2, 4, 1, 1, 2);

        // Enter from MATCH_OVER starts a fresh match.
        enter_button = 1'b1;
        c0 = cyc;
        n  = 0;
        while (!game_reset && n < 40) begin
            tick();
            n++;
        end
        checkOutput("restart game_reset cycle", cyc, c0 + ENTER_LATENCY + 1);
        checkAll("new match", 0, 0, 0, 0, 0, 0);
        repeat (12) tick();
        enter_button = 1'b0;
        repeat (12) tick();

        // Score 1-0, then reset partway through the hold.
        p1_win = 1'b1;
        tick();
        p1_win = 1'b0;
        checkAll("new match p1 win", 1, 0, 1, 0, 0, 0);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        checkOutput("game_reset in reset cycle", 32'(game_reset), 1);
        tick();
        reset = 1'b0;
        #1;
        checkAll("after mid-hold reset", 0, 0, 0, 0, 0, 0);
        checkOutput("game_reset after mid-hold reset", 32'(game_reset), 0);
        highs = 0;
        repeat (HOLD + 4) begin
            tick();
            if (game_reset || match_over) highs++;
        end
        checkOutput("stays IDLE after reset", highs, 0);
        checkOutput("pending game_enter", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
